// File: rtl/ret_addr_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : ret_addr_stack_if
// Description : Bundle between the fetch/decode control path (master) and the
//               hardware return-address stack (slave).
//                 push       - CALL retiring this cycle
//                 push_addr  - return address to save (pc_plus1 of the CALL)
//                 pop        - RET retiring this cycle
//                 flush      - pipeline flush / exception, empties the stack
//                 ret_addr   - current top entry, zero when empty
//                 empty/full - occupancy status
//                 count      - number of valid entries
//                 overflow   - sticky, push attempted while full
//                 underflow  - sticky, pop attempted while empty
// Revision    : 1.0 - initial release
// ============================================================================
interface ret_addr_stack_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic               push;
    logic [AW-1:0]      push_addr;
    logic               pop;
    logic               flush;
    logic [AW-1:0]      ret_addr;
    logic               empty;
    logic               full;
    logic [c_CNT_W-1:0] count;
    logic               overflow;
    logic               underflow;

    // Control path side: issues CALL/RET/flush, consumes the return address.
    modport master (
        output push, push_addr, pop, flush,
        input  ret_addr, empty, full, count, overflow, underflow
    );

    // Stack side.
    modport slave (
        input  push, push_addr, pop, flush,
        output ret_addr, empty, full, count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/ret_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_addr_stack
// Description : Hardware return-address stack feeding the PC next-address
//               mux. A CALL pushes its pc_plus1, a RET presents the top entry
//               on ret_addr (combinationally, same cycle) and pops it.
//               Per-cycle priority: flush, then the push/pop combination.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - ret_addr_stack_if.slave (push, push_addr, pop, flush,
//                        ret_addr, empty, full, count, overflow, underflow)
// Config      : RAS_WRAP_EN - when defined, a push while full overwrites the
//               oldest entry circularly; when undefined, that push is dropped.
//               Either way the overflow flag is set.
// Revision    : 1.0 - initial release
// ============================================================================
module ret_addr_stack #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int AW    = 8    // matches PC width
) (
    input  wire               clk,
    input  wire               rst_n,
    ret_addr_stack_if.slave   bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [AW-1:0]      r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_tp;          // next free slot; top is r_tp-1
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    // ------------------------------------------------------------------------
    // Status and read side
    // ------------------------------------------------------------------------
    logic               w_empty;
    logic               w_full;
    logic [c_PTR_W-1:0] w_top_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL_CNT);
    // Pointer is exactly c_PTR_W bits wide, so the decrement wraps mod DEPTH.
    assign w_top_idx = r_tp - 1'b1;

    // Zero when empty so a stray RET never steers the PC to stale data.
    assign bus.ret_addr  = w_empty ? '0 : r_mem[w_top_idx];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

    // ------------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------------
    logic               w_wr_en;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic [c_PTR_W-1:0] w_tp_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_ovf_set;
    logic               w_unf_set;

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = r_tp;
        w_tp_nxt    = r_tp;
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;

        if (bus.flush) begin
            // Array contents are left alone; count/tp make them invisible.
            w_tp_nxt    = '0;
            w_count_nxt = '0;
        end else begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (!w_full) begin
                        w_wr_en     = 1'b1;
                        w_tp_nxt    = r_tp + 1'b1;
                        w_count_nxt = r_count + 1'b1;
                    end else begin
                        w_ovf_set = 1'b1;
`ifdef RAS_WRAP_EN
                        // Circular overwrite of the oldest entry; the slot at
                        // r_tp is the oldest one when the stack is full.
                        w_wr_en  = 1'b1;
                        w_tp_nxt = r_tp + 1'b1;
`endif
                    end
                end
                2'b01: begin
                    if (!w_empty) begin
                        w_tp_nxt    = r_tp - 1'b1;
                        w_count_nxt = r_count - 1'b1;
                    end else begin
                        w_unf_set = 1'b1;
                    end
                end
                2'b11: begin
                    if (!w_empty) begin
                        // RET and CALL together: replace top in place.
                        w_wr_en  = 1'b1;
                        w_wr_idx = w_top_idx;
                    end else begin
                        // Nothing to pop: behave as a plain push (an empty
                        // stack is never full for DEPTH >= 2).
                        w_wr_en     = 1'b1;
                        w_tp_nxt    = r_tp + 1'b1;
                        w_count_nxt = r_count + 1'b1;
                        w_unf_set   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.push_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_tp    <= w_tp_nxt;
            r_count <= w_count_nxt;
            if (bus.flush) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_overflow  <= r_overflow  | w_ovf_set;
                r_underflow <= r_underflow | w_unf_set;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ret_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_ret_addr_stack
// Description : Self-checking bench for ret_addr_stack (DEPTH=4, AW=8).
//               Directed steps from the test plan followed by a random
//               CALL/RET/flush stream, all compared against a queue-based
//               reference model of a return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ret_addr_stack;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic clk;
    logic rst_n;

    ret_addr_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    ret_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: back of the queue is the top of stack.
    logic [AW-1:0] m_q[$];
    logic          m_ovf;
    logic          m_unf;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_apply(input logic p, input logic [AW-1:0] a,
                               input logic q, input logic f);
        if (f) begin
            model_reset();
        end else if (p && q) begin
            if (m_q.size() > 0) begin
                m_q[m_q.size()-1] = a;
            end else begin
                m_q.push_back(a);
                m_unf = 1'b1;
            end
        end else if (p) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(a);
            end else begin
                m_ovf = 1'b1;
`ifdef RAS_WRAP_EN
                void'(m_q.pop_front());
                m_q.push_back(a);
`endif
            end
        end else if (q) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_unf = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [AW-1:0] e_ret;
        e_ret = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
        chk({tag, ".ret_addr"},  32'(bus.ret_addr),  32'(e_ret));
        chk({tag, ".count"},     32'(bus.count),     32'(m_q.size()));
        chk({tag, ".empty"},     32'(bus.empty),     32'(m_q.size() == 0));
        chk({tag, ".full"},      32'(bus.full),      32'(m_q.size() == DEPTH));
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
    endtask

    // One clock cycle of stimulus; inputs change on the falling edge and the
    // outputs are checked 1 time unit after the rising edge.
    task automatic step(input string tag, input logic p, input logic [AW-1:0] a,
                        input logic q, input logic f);
        @(negedge clk);
        bus.push      = p;
        bus.push_addr = a;
        bus.pop       = q;
        bus.flush     = f;
        @(posedge clk);
        model_apply(p, a, q, f);
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        bus.push      = 1'b0;
        bus.push_addr = '0;
        bus.pop       = 1'b0;
        bus.flush     = 1'b0;
    endtask

    logic [AW-1:0] exp_pops [4];

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ret_addr",  32'(bus.ret_addr),  32'h0);
        chk("reset.count",     32'(bus.count),     32'h0);
        chk("reset.empty",     32'(bus.empty),     32'h1);
        chk("reset.full",      32'(bus.full),      32'h0);
        chk("reset.overflow",  32'(bus.overflow),  32'h0);
        chk("reset.underflow", 32'(bus.underflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic LIFO order
        step("push10", 1'b1, 8'h10, 1'b0, 1'b0);
        step("push20", 1'b1, 8'h20, 1'b0, 1'b0);
        step("push30", 1'b1, 8'h30, 1'b0, 1'b0);
        chk("lifo.top",   32'(bus.ret_addr), 32'h30);
        chk("lifo.count", 32'(bus.count),    32'h3);
        step("pop1", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("lifo.pop1", 32'(bus.ret_addr), 32'h20);
        step("pop2", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("lifo.pop2", 32'(bus.ret_addr), 32'h10);
        step("pop3", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("lifo.pop3",  32'(bus.ret_addr),  32'h00);
        chk("lifo.empty", 32'(bus.empty),     32'h1);
        chk("lifo.unf",   32'(bus.underflow), 32'h0);

        // Underflow and flush
        step("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf.flag",  32'(bus.underflow), 32'h1);
        chk("unf.count", 32'(bus.count),     32'h0);
        chk("unf.ret",   32'(bus.ret_addr),  32'h0);
        step("flush1", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("unf.cleared", 32'(bus.underflow), 32'h0);

        // Overfill a DEPTH=4 stack with 01..05
        for (int i = 1; i <= 5; i++) step("fill", 1'b1, AW'(i), 1'b0, 1'b0);
`ifdef RAS_WRAP_EN
        chk("ovf.top", 32'(bus.ret_addr), 32'h05);
        exp_pops = '{8'h05, 8'h04, 8'h03, 8'h02};
`else
        chk("ovf.top", 32'(bus.ret_addr), 32'h04);
        exp_pops = '{8'h04, 8'h03, 8'h02, 8'h01};
`endif
        chk("ovf.full", 32'(bus.full),     32'h1);
        chk("ovf.flag", 32'(bus.overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf.ret_before_pop", 32'(bus.ret_addr), 32'(exp_pops[i]));
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("ovf.drained", 32'(bus.empty), 32'h1);
        step("flush2", 1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous push+pop
        step("push40", 1'b1, 8'h40, 1'b0, 1'b0);
        step("pp50",   1'b1, 8'h50, 1'b1, 1'b0);
        chk("pp.count", 32'(bus.count),    32'h1);
        chk("pp.ret",   32'(bus.ret_addr), 32'h50);
        step("flush3", 1'b0, 8'h00, 1'b0, 1'b1);
        step("pp60",   1'b1, 8'h60, 1'b1, 1'b0);
        chk("ppe.count", 32'(bus.count),     32'h1);
        chk("ppe.ret",   32'(bus.ret_addr),  32'h60);
        chk("ppe.unf",   32'(bus.underflow), 32'h1);

        // Flush wins over push
        step("pushAA", 1'b1, 8'hAA, 1'b0, 1'b0);
        step("pushBB", 1'b1, 8'hBB, 1'b0, 1'b0);
        step("flushCC", 1'b1, 8'hCC, 1'b0, 1'b1);
        chk("fl.count", 32'(bus.count),     32'h0);
        chk("fl.empty", 32'(bus.empty),     32'h1);
        chk("fl.ret",   32'(bus.ret_addr),  32'h0);
        chk("fl.unf",   32'(bus.underflow), 32'h0);
        chk("fl.ovf",   32'(bus.overflow),  32'h0);

        // Asynchronous reset between clock edges
        step("pushR1", 1'b1, 8'h11, 1'b0, 1'b0);
        step("pushR2", 1'b1, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.ret",   32'(bus.ret_addr), 32'h0);
        chk("arst.count", 32'(bus.count),    32'h0);
        chk("arst.empty", 32'(bus.empty),    32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step("push77", 1'b1, 8'h77, 1'b0, 1'b0);
        chk("arst.push_ret",   32'(bus.ret_addr), 32'h77);
        chk("arst.push_count", 32'(bus.count),    32'h1);

        // Random CALL/RET/flush stream, back to back with no idle cycles
        for (int n = 0; n < 400; n++) begin
            logic rp, rq, rf;
            rf = ($urandom_range(0, 99) < 4);
            rp = ($urandom_range(0, 99) < 55);
            rq = ($urandom_range(0, 99) < 50);
            step("rand", rp, AW'($urandom_range(0, 255)), rq, rf);
        end

        @(negedge clk);
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ret_addr_stack.md
# ret_addr_stack

Hardware return-address stack that produces the `ret_addr` operand consumed by the PC next-address mux. On a CALL it pushes the return address (`pc_plus1` of the call instruction). On a RET it presents the top entry as `ret_addr` and pops it. It sits in the fetch/decode control path, beside the program counter register, and is the producer end of the return-select path.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `AW`, 8, address width; matches the PC width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `push`  in  1  CALL retiring this cycle; write `push_addr`.
- `push_addr`  in  AW  return address to save (`pc_plus1` of the CALL).
- `pop`  in  1  RET retiring this cycle; discard the top entry.
- `flush`  in  1  pipeline flush or exception; empty the stack and clear flags.
- `ret_addr`  out  AW  current top entry; `{AW{1'b0}}` when empty.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `count`  out  $clog2(DEPTH+1)  number of valid entries.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- Storage is a `DEPTH`×`AW` register array plus a `$clog2(DEPTH)`-bit top pointer `tp` and `count`.
- `ret_addr` = `mem[tp-1]` (mod DEPTH) when `count != 0`, else 0. It is combinational from registered state and has no read latency.
- Priority per cycle is `flush` > (`push`,`pop`) combination.
- `flush`: count←0, tp←0, overflow←0, underflow←0. Array contents are don't-care.
- push only, not full: mem[tp]←push_addr, tp←tp+1, count←count+1.
- push only, full: see Configuration.
- pop only, not empty: tp←tp-1, count←count-1.
- pop only, empty: no state change except underflow←1.
- push+pop, not empty: the top entry is replaced (mem[tp-1]←push_addr); tp and count are unchanged. This covers a tail-call or a RET and CALL retiring together.
- push+pop, empty: treated as a push; underflow←1.
- Pointer arithmetic wraps modulo DEPTH. `count` saturates at DEPTH and never wraps.
- Flags stay set until `flush` or reset.

## Timing
- Reset (async assert, sync release by the system): count=0, tp=0, ret_addr=0, empty=1, full=0, overflow=0, underflow=0. Array entries reset to 0.
- A push at edge N is visible on `ret_addr`, `count` and `full` right after edge N.
- A pop at edge N exposes the next-older entry right after edge N.
- The consumer samples `ret_addr` combinationally in the same cycle that it asserts `pop` and selects the return path.
- Reset asserted mid-operation clears everything immediately and asynchronously, independent of `clk`.
- Back-to-back push/pop every cycle is supported, with no bubbles.

## Configuration
- `RAS_WRAP_EN` defined, push while full (no pop): the oldest entry is overwritten circularly. mem[tp]←push_addr, tp←tp+1, count stays DEPTH, overflow←1. The most recent DEPTH returns are always correct.
- `RAS_WRAP_EN` undefined, push while full (no pop): the push is dropped and state is unchanged except overflow←1. The existing DEPTH entries are preserved.

## Test plan
- Reset, then push 8'h10, 8'h20, 8'h30 -> ret_addr 8'h30 and count=3. Pop three times -> ret_addr steps 8'h20, 8'h10, 8'h00, then empty=1, underflow=0.
- Pop while empty -> underflow=1, count=0, ret_addr=0. Flush -> underflow=0.
- DEPTH=4: push 8'h01..8'h05.
  - With `RAS_WRAP_EN`: ret_addr=8'h05, full=1, overflow=1; four pops return 05, 04, 03, 02.
  - Without it: ret_addr=8'h04; four pops return 04, 03, 02, 01.
- Push 8'h40, then push+pop with push_addr 8'h50 -> count=1, ret_addr=8'h50. Push+pop while empty with 8'h60 -> count=1, ret_addr=8'h60, underflow=1.
- Push 8'hAA and 8'hBB, then drive flush and push together -> count=0, empty=1, flags cleared, and 8'hCC is not stored.
- Push two entries, then assert rst_n=0 between clock edges -> outputs reach reset values before the next edge. After release, the first push of 8'h77 gives ret_addr=8'h77, count=1.
